// File: rtl/pip_reg_skid_if.sv
// pip_reg_skid_if: valid/ready handshake bundle carrying control and datapath fields.
// Rev 1.0 - initial release.
`default_nettype none

interface pip_reg_skid_if #(
  parameter int CTRL_WIDTH = 10,
  parameter int DATA_WIDTH = 165
);
  logic                  valid;
  logic                  ready;
  logic [CTRL_WIDTH-1:0] ctrl;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, output ctrl, output data, input ready);
  modport slave  (input valid, input ctrl, input data, output ready);
endinterface

`default_nettype wire

// File: rtl/pip_reg_skid.sv
// pip_reg_skid: decode-to-execute register with one-entry skid buffer and flush.
// Rev 1.0 - optional saturating perf counters enabled by PIP_REG_PERF_EN.
`default_nettype none

module pip_reg_skid #(
  parameter int CTRL_WIDTH = 10,
  parameter int DATA_WIDTH = 165,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  pip_reg_skid_if.slave        up_if,
  pip_reg_skid_if.master       dn_if,
  output logic [CNT_WIDTH-1:0] stall_cnt_o,
  output logic [CNT_WIDTH-1:0] bubble_cnt_o,
  output logic [CNT_WIDTH-1:0] flush_cnt_o
);

  // State bits are {main_valid, skid_valid}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b10,
    ST_SKID  = 2'b11
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CTRL_WIDTH-1:0] r_main_ctrl;
  logic [DATA_WIDTH-1:0] r_main_data;
  logic [CTRL_WIDTH-1:0] r_skid_ctrl;
  logic [DATA_WIDTH-1:0] r_skid_data;
  logic                  w_main_valid;
  logic                  w_ready;
  logic                  w_in;
  logic                  w_out;
  logic                  w_load_main_in;
  logic                  w_load_main_skid;
  logic                  w_load_skid;

  assign w_main_valid = r_state[1];
  assign w_ready      = ~r_state[0];
  assign w_in         = up_if.valid & w_ready;
  assign w_out        = w_main_valid & dn_if.ready;

  assign up_if.ready  = w_ready;
  assign dn_if.valid  = w_main_valid;
  assign dn_if.ctrl   = w_main_valid ? r_main_ctrl : '0;
  assign dn_if.data   = r_main_data;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush_i) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in) begin
            w_load_main_in = 1'b1;
            w_state_nxt    = ST_FULL;
          end
        end
        ST_FULL: begin
          if (w_in && w_out) begin
            w_load_main_in = 1'b1;
          end else if (w_in) begin
            w_load_skid = 1'b1;
            w_state_nxt = ST_SKID;
          end else if (w_out) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (w_out) begin
            w_load_main_skid = 1'b1;
            w_state_nxt      = ST_FULL;
          end
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
  end

  // Flush clears main ctrl so a stale bundle can never resurface as a command.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else if (flush_i) begin
      r_main_ctrl <= '0;
    end else begin
      if (w_load_main_in) begin
        r_main_ctrl <= up_if.ctrl;
        r_main_data <= up_if.data;
      end else if (w_load_main_skid) begin
        r_main_ctrl <= r_skid_ctrl;
        r_main_data <= r_skid_data;
      end
      if (w_load_skid) begin
        r_skid_ctrl <= up_if.ctrl;
        r_skid_data <= up_if.data;
      end
    end
  end

`ifdef PIP_REG_PERF_EN
  localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = 1;
  localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = '1;

  logic [CNT_WIDTH-1:0] r_stall_cnt;
  logic [CNT_WIDTH-1:0] r_bubble_cnt;
  logic [CNT_WIDTH-1:0] r_flush_cnt;

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else begin
      if (w_main_valid && !dn_if.ready && (r_stall_cnt != C_CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + C_CNT_ONE;
      end
      if (!w_main_valid && (r_bubble_cnt != C_CNT_MAX)) begin
        r_bubble_cnt <= r_bubble_cnt + C_CNT_ONE;
      end
      if (flush_i && (r_flush_cnt != C_CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + C_CNT_ONE;
      end
    end
  end

  assign stall_cnt_o  = r_stall_cnt;
  assign bubble_cnt_o = r_bubble_cnt;
  assign flush_cnt_o  = r_flush_cnt;
`else
  assign stall_cnt_o  = '0;
  assign bubble_cnt_o = '0;
  assign flush_cnt_o  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pip_reg_skid.sv
// tb_pip_reg_skid: directed self-checking bench for pip_reg_skid.
// Rev 1.0 - initial release.
`default_nettype none

module tb_pip_reg_skid;

  localparam int CW = 10;
  localparam int DW = 165;
`ifdef PIP_REG_PERF_EN
  localparam int NW = 4;
`else
  localparam int NW = 32;
`endif

  logic          clk;
  logic          rst;
  logic          flush;
  logic [NW-1:0] stall_cnt;
  logic [NW-1:0] bubble_cnt;
  logic [NW-1:0] flush_cnt;
  int            n_checks;
  int            n_errors;

  pip_reg_skid_if #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW)) up_if ();
  pip_reg_skid_if #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW)) dn_if ();

  pip_reg_skid #(
    .CTRL_WIDTH (CW),
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (NW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .up_if        (up_if),
    .dn_if        (dn_if),
    .stall_cnt_o  (stall_cnt),
    .bubble_cnt_o (bubble_cnt),
    .flush_cnt_o  (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input logic rdy, input logic fl);
    up_if.valid = v;
    up_if.ctrl  = c;
    up_if.data  = d;
    dn_if.ready = rdy;
    flush       = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    // Reset for two cycles with a valid entry offered
    rst = 1'b1;
    drive(1'b1, 10'h155, 165'd99, 1'b1, 1'b0);
    tick();
    tick();
    chk("rst_valid", dn_if.valid, 0);
    chk("rst_ctrl",  dn_if.ctrl,  0);
    chk("rst_data",  dn_if.data,  0);
    chk("rst_ready", up_if.ready, 1);
    chk("rst_stall", stall_cnt,   0);
    chk("rst_flush", flush_cnt,   0);
    rst = 1'b0;
    drive(1'b0, 10'h155, 165'd99, 1'b1, 1'b0);
    tick();
    chk("rst_nocap", dn_if.valid, 0);

    // First entry after reset, one-cycle latency
    drive(1'b1, 10'h2A5, 165'h11, 1'b0, 1'b0);
    tick();
    chk("first_valid", dn_if.valid, 1);
    chk("first_data",  dn_if.data,  165'h11);
    chk("first_ctrl",  dn_if.ctrl,  10'h2A5);
    chk("first_ready", up_if.ready, 1);
    drive(1'b0, 10'h0, 165'h0, 1'b1, 1'b0);
    tick();
    chk("drain_valid", dn_if.valid, 0);
    chk("drain_ctrl0", dn_if.ctrl,  0);
    chk("drain_hold",  dn_if.data,  165'h11);

    // Streaming 0..7 back to back
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, CW'(i + 1), DW'(i), 1'b1, 1'b0);
      tick();
      chk("stream_valid", dn_if.valid, 1);
      chk("stream_data",  dn_if.data,  DW'(i));
      chk("stream_ctrl",  dn_if.ctrl,  CW'(i + 1));
      chk("stream_ready", up_if.ready, 1);
    end
    drive(1'b0, 10'h0, 165'h0, 1'b1, 1'b0);
    tick();
    chk("stream_end", dn_if.valid, 0);

    // Backpressure: A, B, C
    drive(1'b1, 10'h00A, 165'hA, 1'b1, 1'b0);
    tick();
    chk("bp_a", dn_if.data, 165'hA);
    drive(1'b1, 10'h00B, 165'hB, 1'b0, 1'b0);
    tick();
    chk("bp_hold_a",  dn_if.data,  165'hA);
    chk("bp_ready0",  up_if.ready, 0);
    drive(1'b1, 10'h00C, 165'hC, 1'b0, 1'b0);
    tick();
    chk("bp_still_a", dn_if.data,  165'hA);
    chk("bp_still_r", up_if.ready, 0);
    drive(1'b1, 10'h00C, 165'hC, 1'b1, 1'b0);
    tick();
    chk("bp_b",       dn_if.data,  165'hB);
    chk("bp_b_ctrl",  dn_if.ctrl,  10'h00B);
    chk("bp_ready1",  up_if.ready, 1);
    drive(1'b1, 10'h00C, 165'hC, 1'b1, 1'b0);
    tick();
    chk("bp_c", dn_if.data, 165'hC);
    drive(1'b0, 10'h0, 165'h0, 1'b1, 1'b0);
    tick();
    chk("bp_empty", dn_if.valid, 0);

    // Flush held for three cycles with entries offered
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 10'h3FF, DW'(32'hF0 + i), 1'b1, 1'b1);
      tick();
      chk("hflush_valid", dn_if.valid, 0);
      chk("hflush_ready", up_if.ready, 1);
    end
`ifdef PIP_REG_PERF_EN
    chk("flush_cnt3", flush_cnt, 3);
`endif
    drive(1'b0, 10'h0, 165'h0, 1'b1, 1'b0);
    tick();
    chk("hflush_none", dn_if.valid, 0);

    // Flush while in SKID with D offered
    drive(1'b1, 10'h0A1, 165'hA1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 10'h0B1, 165'hB1, 1'b0, 1'b0);
    tick();
    chk("fskid_r0", up_if.ready, 0);
    drive(1'b1, 10'h0D1, 165'hD1, 1'b1, 1'b1);
    tick();
    chk("fskid_valid", dn_if.valid, 0);
    chk("fskid_ctrl",  dn_if.ctrl,  0);
    chk("fskid_ready", up_if.ready, 1);
    drive(1'b0, 10'h0, 165'h0, 1'b1, 1'b0);
    tick();
    chk("fskid_noD", dn_if.valid, 0);

    // Simultaneous IN and OUT in FULL
    drive(1'b1, 10'h0A2, 165'hA2, 1'b1, 1'b0);
    tick();
    drive(1'b1, 10'h0B2, 165'hB2, 1'b1, 1'b0);
    tick();
    chk("inout_data",  dn_if.data,  165'hB2);
    chk("inout_ready", up_if.ready, 1);
    drive(1'b0, 10'h0, 165'h0, 1'b1, 1'b0);
    tick();
    chk("inout_empty", dn_if.valid, 0);
    chk("inout_rdy",   up_if.ready, 1);

    // Long stall: output stays stable
    drive(1'b1, 10'h0EE, 165'hE, 1'b0, 1'b0);
    tick();
    drive(1'b0, 10'h0, 165'h0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    chk("stall_valid", dn_if.valid, 1);
    chk("stall_data",  dn_if.data,  165'hE);
    chk("stall_ctrl",  dn_if.ctrl,  10'h0EE);
`ifdef PIP_REG_PERF_EN
    chk("stall_sat", stall_cnt, 15);
    chk("flush_cnt4", flush_cnt, 4);
`else
    chk("cnt_stall0",  stall_cnt,  0);
    chk("cnt_bubble0", bubble_cnt, 0);
    chk("cnt_flush0",  flush_cnt,  0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pip_reg_skid.md
# pip_reg_skid

Parametrised decode-to-execute pipeline register with a valid/ready handshake and a one-entry skid buffer. Replaces the plain enable-gated stage register between decode and execute: it carries a control bundle and a datapath bundle, breaks the combinational ready path, supports synchronous flush with bubble insertion, and sustains one transfer per cycle. It sits between the decode stage, which produces control and operands, and the execute stage, which consumes them.

## Interface
- CTRL_WIDTH, 10, control bundle width: RegWrite, ResultSrc[1:0], MemWrite, Jump, Branch, ALUControl[2:0], ALUSrc. Zeroed in bubbles.
- DATA_WIDTH, 165, datapath bundle width: RD1, RD2, PC, ImmExt, PCPlus4 (5×32) plus Rd (5).
- CNT_WIDTH, 32, performance counter width. Used only with PIP_REG_PERF_EN.
- clk_i  in  1  sole clock; all state updates on posedge.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  synchronous flush. Discards all held and incoming entries.
- valid_i  in  1  upstream (decode) entry valid.
- ready_o  out  1  register can accept an entry; driven from state only.
- ctrl_i  in  CTRL_WIDTH  upstream control bundle.
- data_i  in  DATA_WIDTH  upstream datapath bundle.
- valid_o  out  1  downstream (execute) entry valid.
- ready_i  in  1  downstream accepts the entry.
- ctrl_o  out  CTRL_WIDTH  control to execute; all-zero whenever valid_o=0.
- data_o  out  DATA_WIDTH  datapath to execute; holds its last value whenever valid_o=0.
- stall_cnt_o, bubble_cnt_o, flush_cnt_o  out  CNT_WIDTH  performance counters (see Configuration).

## Operation
- Handshake rules:
  - Upstream accept (IN) = valid_i & ready_o.
  - Downstream transfer (OUT) = valid_o & ready_i.
  - valid_o stays asserted, and ctrl_o/data_o stay stable, until OUT.
- Storage:
  - Main entry drives the outputs.
  - Skid entry holds one overflow entry.
  - ready_o = !skid_valid.
- State machine; state is encoded by {main_valid, skid_valid}:
  - EMPTY (0,0):
    - IN → main ← input, go to FULL.
  - FULL (1,0):
    - IN & OUT → main ← input, stay in FULL.
    - IN & !OUT → skid ← input, go to SKID.
    - !IN & OUT → go to EMPTY.
    - Neither → hold.
  - SKID (1,1): ready_o=0, so IN cannot occur.
    - OUT → main ← skid, go to FULL.
    - Otherwise hold.
  - (0,1) is unreachable. Recovery from it is not required.
- Flush, when flush_i=1 on an edge:
  - main_valid, skid_valid ← 0 and main ctrl ← 0.
  - Any entry presented that cycle is discarded, even if IN or OUT is true.
  - Next state is EMPTY.
- Priority: rst_i > flush_i > normal handshake.
- Ordering: strict FIFO. No entry is duplicated or lost except by flush or reset.
- ctrl_o is forced to 0 while valid_o=0, so a bubble performs no register write, memory write, or branch.

## Timing
- Latency: an entry accepted at edge N appears on valid_o/ctrl_o/data_o after edge N (1 cycle) when the block is EMPTY or FULL with OUT.
- Throughput: 1 entry/cycle sustained while ready_i=1.
- After one cycle with ready_i=0 in FULL with IN, ready_o=0 from the next cycle. It returns to 1 the cycle after the first OUT.
- No combinational path from ready_i to ready_o, or from valid_i to valid_o.
- Reset values, applied on any edge with rst_i=1:
  - valid_o=0, ready_o=1, ctrl_o=0, data_o=0, state EMPTY, counters 0.
  - Handshakes during rst_i=1 are ignored.
- Reset or flush mid-SKID: both entries dropped and ready_o=1 on the next cycle.
- flush_i held for several cycles: the block remains EMPTY with ready_o=1 and every IN is discarded.

## Configuration
- Macro: PIP_REG_PERF_EN.
- Defined: three saturating counters, each clearing on rst_i only (not on flush):
  - stall_cnt_o increments each cycle with valid_o & !ready_i.
  - bubble_cnt_o increments each cycle with !valid_o.
  - flush_cnt_o increments each cycle with flush_i.
  - Each holds at 2^CNT_WIDTH−1.
- Undefined: counter ports remain, tied to constant 0. No counter flops are synthesised.

## Test plan
- Reset: rst_i=1 for 2 cycles with valid_i=1 → valid_o=0, ctrl_o=0, ready_o=1 and no entry captured. First IN afterwards appears one cycle later.
- Streaming: ready_i=1, 8 back-to-back entries with data_i=0..7 → data_o=0..7 on consecutive cycles, 1-cycle latency, ready_o constantly 1.
- Backpressure: stream A,B,C with ready_i=0 from the cycle A is output →
  - B goes to skid and ready_o=0, so C is held upstream.
  - Releasing ready_i yields A, B, C in order with no loss.
- Flush in SKID: main=A, skid=B, flush_i=1 with valid_i=1 (D) → next cycle valid_o=0, ctrl_o=0, ready_o=1. D is not output.
- Simultaneous IN & OUT in FULL: main=A, input B, ready_i=1 → next cycle data_o=B, skid stays empty, ready_o=1.
- PIP_REG_PERF_EN defined, CNT_WIDTH=4:
  - 20 stall cycles → stall_cnt_o saturates at 15.
  - 3 flush cycles → flush_cnt_o=3.
  - Macro undefined → all counters read 0.
